// File: rtl/lfsr_fifo_pkg.sv
// Shared register map, bit positions and STATUS layout for the LFSR sample FIFO.
package lfsr_fifo_pkg;

  localparam logic [15:0] ADDR_DATA   = 16'h0016;
  localparam logic [15:0] ADDR_STATUS = 16'h0018;
  localparam logic [15:0] ADDR_CTRL   = 16'h001A;

  localparam int unsigned CTRL_EN_BIT    = 0;
  localparam int unsigned CTRL_DECIM_LSB = 8;
  localparam int unsigned CTRL_CLEAR_BIT = 31;

  localparam int unsigned STAT_COUNT_LSB     = 0;
  localparam int unsigned STAT_FULL_BIT      = 8;
  localparam int unsigned STAT_EMPTY_BIT     = 9;
  localparam int unsigned STAT_UNDERFLOW_BIT = 10;
  localparam int unsigned STAT_OVERFLOW_BIT  = 11;
  localparam int unsigned STAT_OVF_CNT_LSB   = 16;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_DATA,
    REG_STATUS,
    REG_CTRL
  } t_reg_sel;

  typedef struct packed {
    logic [31:0] rsvd_hi;
    logic [15:0] ovf_cnt;
    logic [3:0]  rsvd_lo;
    logic        overflow;
    logic        underflow;
    logic        empty;
    logic        full;
    logic [7:0]  count;
  } t_fifo_status;

  function automatic t_reg_sel decode_addr(input logic [15:0] addr);
    case (addr)
      ADDR_DATA:   return REG_DATA;
      ADDR_STATUS: return REG_STATUS;
      ADDR_CTRL:   return REG_CTRL;
      default:     return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_sample_fifo_sync_fifo.sv
// Single-clock FIFO with synchronous clear; push while full succeeds only with a same-cycle pop.
module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty
);

  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/lfsr_sample_fifo.sv
// LFSR capture buffer: decimates LFSR steps into a FIFO drained by pop-on-read MMIO.
module lfsr_sample_fifo
  import lfsr_fifo_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  sample_in,
  input  logic          sample_valid,
  input  logic          mmio_wr,
  input  logic          mmio_rd,
  input  logic [15:0]   mmio_addr,
  input  logic [63:0]   mmio_wdata,
  output logic          rd_hit,
  output logic [63:0]   rd_data,
  output logic          full,
  output logic          empty
);

  t_reg_sel     sel;
  logic         wr_ctrl;
  logic         clear;
  logic         pop;
  logic         capture;
  logic         drop;
  logic         en;
  logic [7:0]   decim;
  logic [7:0]   dc;
  logic         underflow;
  logic         overflow;
  logic [15:0]  ovf_cnt;
  logic [N-1:0] fifo_dout;
  logic [AW:0]  fifo_count;
  t_fifo_status status;
  logic [63:0]  ctrl_rd;
  logic [63:0]  rsp_data;
  logic         unused_wdata;

  assign sel          = decode_addr(mmio_addr);
  assign wr_ctrl      = mmio_wr && (sel == REG_CTRL);
  assign clear        = wr_ctrl && mmio_wdata[CTRL_CLEAR_BIT];
  assign pop          = mmio_rd && (sel == REG_DATA);
  assign capture      = sample_valid && en && (dc == decim);
  // A pop while full frees the slot this cycle, so the capture is not lost.
  assign drop         = capture && full && !pop;
  assign unused_wdata = ^{mmio_wdata[63:32], mmio_wdata[30:16], mmio_wdata[7:1]};

  sync_fifo #(
    .W     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .push  (capture),
    .pop   (pop),
    .din   (sample_in),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      en    <= 1'b0;
      decim <= '0;
    end else if (wr_ctrl) begin
      en    <= mmio_wdata[CTRL_EN_BIT];
      decim <= mmio_wdata[CTRL_DECIM_LSB +: 8];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset || wr_ctrl) begin
      dc <= '0;
    end else if (sample_valid && en) begin
      dc <= capture ? 8'd0 : dc + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      underflow <= 1'b0;
      overflow  <= 1'b0;
      ovf_cnt   <= '0;
    end else begin
      if (pop && empty) underflow <= 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (ovf_cnt != '1) ovf_cnt <= ovf_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    status = '0;
    status[STAT_COUNT_LSB +: 8]    = 8'(fifo_count);
    status[STAT_FULL_BIT]          = full;
    status[STAT_EMPTY_BIT]         = empty;
    status[STAT_UNDERFLOW_BIT]     = underflow;
    status[STAT_OVERFLOW_BIT]      = overflow;
    status[STAT_OVF_CNT_LSB +: 16] = ovf_cnt;

    ctrl_rd = '0;
    ctrl_rd[CTRL_EN_BIT]          = en;
    ctrl_rd[CTRL_DECIM_LSB +: 8]  = decim;

    rsp_data = '0;
    case (sel)
      REG_DATA:   rsp_data = empty ? 64'd0 : 64'(fifo_dout);
      REG_STATUS: rsp_data = status;
      REG_CTRL:   rsp_data = ctrl_rd;
      default:    rsp_data = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_hit  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_hit  <= mmio_rd && (sel != REG_NONE);
      rd_data <= rsp_data;
    end
  end

endmodule
